// File: rtl/regfile_mp_sb_if.sv
// Register-file bus: read ports, write/writeback ports, issue reservation
// and scoreboard status. The master is the issue/writeback side; the slave
// is the register file.
interface regfile_mp_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
);
  logic [NUM_RD*ADDR_W-1:0] rs_addr;
  logic [NUM_RD*DATA_W-1:0] rs_data;
  logic [NUM_RD-1:0]        rs_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_WR-1:0]        wr_release;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_ready;
  logic                     flush;
  logic                     sb_underflow;

  modport master (
    output rs_addr, wr_en, wr_addr, wr_data, wr_release, rsv_en, rsv_addr, flush,
    input  rs_data, rs_busy, rsv_ready, sb_underflow
  );

  modport slave (
    input  rs_addr, wr_en, wr_addr, wr_data, wr_release, rsv_en, rsv_addr, flush,
    output rs_data, rs_busy, rsv_ready, sb_underflow
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with per-register pending-write counters.
// Reads are combinational with write-through bypass; the highest-index write
// port wins on address collisions. Counters let issue logic see RAW hazards.
module regfile_mp_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2,
  parameter int unsigned PEND_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  regfile_mp_sb_if.slave  bus
);
  localparam int unsigned NREGS = 1 << ADDR_W;
  localparam int unsigned REL_W = $clog2(NUM_WR + 1);
  localparam int unsigned CW    = ((REL_W > PEND_W) ? REL_W : PEND_W) + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0]  valid;
  logic [PEND_W-1:0] cnt [NREGS];
  logic              underflow_q;

  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [ADDR_W-1:0] ra [NUM_RD];
  logic [REL_W-1:0]  rel [NREGS];
  logic [PEND_W-1:0] cnt_after [NREGS];
  logic              uf_any;

  // Unpack the flat write and read port buses.
  always_comb begin
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      wa[w] = bus.wr_addr[w*ADDR_W +: ADDR_W];
      wd[w] = bus.wr_data[w*DATA_W +: DATA_W];
    end
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra[i] = bus.rs_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Per-register release count, and counter value after releases saturate at zero.
  always_comb begin
    logic [CW-1:0] rel_x;
    logic [CW-1:0] cnt_x;
    logic [CW-1:0] dec;
    uf_any = 1'b0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      rel[r] = '0;
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && bus.wr_release[w] && r != 0 && wa[w] == ADDR_W'(r))
          rel[r] = rel[r] + REL_W'(1);
      end
      rel_x = CW'(rel[r]);
      cnt_x = CW'(cnt[r]);
      dec   = (rel_x > cnt_x) ? cnt_x : rel_x;
      cnt_after[r] = PEND_W'(cnt_x - dec);
      if (rel_x > cnt_x)
        uf_any = 1'b1;
    end
  end

  // Reservation acceptance: register 0 always accepts, others until the counter is full.
  always_comb begin
    bus.rsv_ready = !reset && (bus.rsv_addr == '0 || cnt[bus.rsv_addr] != PEND_MAX);
  end

  // Read path: x0 -> 0, then newest bypassed write, then valid stored value.
  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      logic [DATA_W-1:0] d;
      d = '0;
      if (!reset && ra[i] != '0) begin
        if (valid[ra[i]])
          d = mem[ra[i]];
        for (int unsigned w = 0; w < NUM_WR; w++) begin
          if (bus.wr_en[w] && wa[w] == ra[i])
            d = wd[w];
        end
      end
      bus.rs_data[i*DATA_W +: DATA_W] = d;
      bus.rs_busy[i] = !reset && ra[i] != '0 && cnt_after[ra[i]] != '0;
    end
  end

  assign bus.sb_underflow = underflow_q;

  // Data array: later loop iterations overwrite earlier ones, so the highest port wins.
  always_ff @(posedge clk) begin
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (bus.wr_en[w] && wa[w] != '0)
        mem[wa[w]] <= wd[w];
    end
  end

  // Valid bits: set on any committed write, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && wa[w] != '0)
          valid[wa[w]] <= 1'b1;
      end
    end
  end

  // Scoreboard counters and sticky underflow; flush overrides reserve/release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++)
        cnt[r] <= '0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      for (int unsigned r = 0; r < NREGS; r++)
        cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        // cnt_after never exceeds cnt, and ready guarantees cnt < max, so +1 cannot wrap.
        if (bus.rsv_en && bus.rsv_ready && r != 0 && bus.rsv_addr == ADDR_W'(r))
          cnt[r] <= cnt_after[r] + PEND_W'(1);
        else
          cnt[r] <= cnt_after[r];
      end
      if (uf_any)
        underflow_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed testbench for regfile_mp_sb (default parameters).
module tb_regfile_mp_sb;
  logic clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) bus ();

  regfile_mp_sb #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .PEND_W(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    bus.wr_en      = '0;
    bus.wr_release = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.rsv_en     = 1'b0;
    bus.rsv_addr   = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.rs_addr = {5'd0, 5'd5};
    repeat (3) @(negedge clk);
    #1;
    vec_cnt++;
    if (bus.rsv_ready !== 1'b0) begin
      $display("FAIL reset_rsv_ready: got %b expected 0", bus.rsv_ready); err_cnt++;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vec_cnt++;
    if (bus.rs_data !== 64'h0) begin
      $display("FAIL reset_rs_data: got %h expected 0", bus.rs_data); err_cnt++;
    end
    vec_cnt++;
    if (bus.rs_busy !== 2'b00) begin
      $display("FAIL reset_rs_busy: got %b expected 00", bus.rs_busy); err_cnt++;
    end
    vec_cnt++;
    if (bus.sb_underflow !== 1'b0) begin
      $display("FAIL reset_underflow: got %b expected 0", bus.sb_underflow); err_cnt++;
    end
  endtask

  task automatic test_write_bypass();
    @(negedge clk);
    idle();
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, 5'd5};
    bus.wr_data = {32'h0, 32'hDEADBEEF};
    bus.rs_addr = {5'd5, 5'd5};
    #1;
    vec_cnt++;
    if (bus.rs_data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      $display("FAIL bypass_x5: got %h expected deadbeefdeadbeef", bus.rs_data); err_cnt++;
    end
    @(negedge clk);
    idle();
    #1;
    vec_cnt++;
    if (bus.rs_data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      $display("FAIL stored_x5: got %h expected deadbeefdeadbeef", bus.rs_data); err_cnt++;
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    idle();
    bus.wr_en   = 2'b11;
    bus.wr_addr = {5'd7, 5'd7};
    bus.wr_data = {32'h22, 32'h11};
    bus.rs_addr = {5'd0, 5'd7};
    #1;
    vec_cnt++;
    if (bus.rs_data[31:0] !== 32'h22) begin
      $display("FAIL prio_bypass_x7: got %h expected 00000022", bus.rs_data[31:0]); err_cnt++;
    end
    @(negedge clk);
    idle();
    bus.wr_en   = 2'b10;
    bus.wr_addr = {5'd0, 5'd0};
    bus.wr_data = {32'h55, 32'h0};
    #1;
    vec_cnt++;
    if (bus.rs_data[31:0] !== 32'h22) begin
      $display("FAIL prio_stored_x7: got %h expected 00000022", bus.rs_data[31:0]); err_cnt++;
    end
    vec_cnt++;
    if (bus.rs_data[63:32] !== 32'h0) begin
      $display("FAIL x0_bypass: got %h expected 00000000", bus.rs_data[63:32]); err_cnt++;
    end
    @(negedge clk);
    idle();
    #1;
    vec_cnt++;
    if (bus.rs_data[63:32] !== 32'h0) begin
      $display("FAIL x0_stored: got %h expected 00000000", bus.rs_data[63:32]); err_cnt++;
    end
  endtask

  task automatic test_reserve_x3();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      bus.rs_addr  = {5'd0, 5'd3};
      bus.rsv_en   = 1'b1;
      bus.rsv_addr = 5'd3;
      #1;
      vec_cnt++;
      if (bus.rsv_ready !== 1'b1) begin
        $display("FAIL rsv_ready_x3_%0d: got %b expected 1", k, bus.rsv_ready); err_cnt++;
      end
      vec_cnt++;
      if (bus.rs_busy[0] !== (k != 0)) begin
        $display("FAIL busy_x3_rsv_%0d: got %b expected %b", k, bus.rs_busy[0], k != 0); err_cnt++;
      end
    end
    @(negedge clk);
    #1;
    vec_cnt++;
    if (bus.rsv_ready !== 1'b0) begin
      $display("FAIL rsv_full_x3: got %b expected 0", bus.rsv_ready); err_cnt++;
    end
    @(negedge clk);
    bus.rsv_en = 1'b0;
    #1;
    vec_cnt++;
    if (bus.rsv_ready !== 1'b0) begin
      $display("FAIL rsv_drop_x3: got %b expected 0", bus.rsv_ready); err_cnt++;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      bus.rs_addr    = {5'd0, 5'd3};
      bus.rsv_addr   = 5'd3;
      bus.wr_en      = 2'b01;
      bus.wr_release = 2'b01;
      bus.wr_addr    = {5'd0, 5'd3};
      bus.wr_data    = {32'h0, 32'h300 + 32'(k)};
      #1;
      vec_cnt++;
      if (bus.rs_busy[0] !== (k != 2)) begin
        $display("FAIL busy_x3_rel_%0d: got %b expected %b", k, bus.rs_busy[0], k != 2); err_cnt++;
      end
      vec_cnt++;
      if (bus.rs_data[31:0] !== 32'h300 + 32'(k)) begin
        $display("FAIL data_x3_rel_%0d: got %h expected %h", k, bus.rs_data[31:0], 32'h300 + 32'(k)); err_cnt++;
      end
    end
    @(negedge clk);
    idle();
    bus.rsv_addr = 5'd3;
    #1;
    vec_cnt++;
    if (bus.rs_busy[0] !== 1'b0) begin
      $display("FAIL busy_x3_done: got %b expected 0", bus.rs_busy[0]); err_cnt++;
    end
    vec_cnt++;
    if (bus.rsv_ready !== 1'b1) begin
      $display("FAIL rsv_ready_x3_done: got %b expected 1", bus.rsv_ready); err_cnt++;
    end
    vec_cnt++;
    if (bus.sb_underflow !== 1'b0) begin
      $display("FAIL underflow_x3: got %b expected 0", bus.sb_underflow); err_cnt++;
    end
  endtask

  task automatic test_release_x4();
    repeat (2) begin
      @(negedge clk);
      idle();
      bus.rsv_en   = 1'b1;
      bus.rsv_addr = 5'd4;
    end
    // cnt=2: reserve plus two releases in one cycle -> busy 0 now, cnt=1 after
    @(negedge clk);
    idle();
    bus.rs_addr    = {5'd0, 5'd4};
    bus.rsv_en     = 1'b1;
    bus.rsv_addr   = 5'd4;
    bus.wr_en      = 2'b11;
    bus.wr_release = 2'b11;
    bus.wr_addr    = {5'd4, 5'd4};
    bus.wr_data    = {32'h42, 32'h41};
    #1;
    vec_cnt++;
    if (bus.rs_busy[0] !== 1'b0) begin
      $display("FAIL busy_x4_dual_rel: got %b expected 0", bus.rs_busy[0]); err_cnt++;
    end
    @(negedge clk);
    idle();
    #1;
    vec_cnt++;
    if (bus.rs_busy[0] !== 1'b1) begin
      $display("FAIL busy_x4_after: got %b expected 1", bus.rs_busy[0]); err_cnt++;
    end
    vec_cnt++;
    if (bus.rs_data[31:0] !== 32'h42) begin
      $display("FAIL data_x4: got %h expected 00000042", bus.rs_data[31:0]); err_cnt++;
    end
    vec_cnt++;
    if (bus.sb_underflow !== 1'b0) begin
      $display("FAIL underflow_x4_none: got %b expected 0", bus.sb_underflow); err_cnt++;
    end
    @(negedge clk);
    idle();
    bus.wr_en      = 2'b10;
    bus.wr_release = 2'b10;
    bus.wr_addr    = {5'd4, 5'd0};
    #1;
    vec_cnt++;
    if (bus.rs_busy[0] !== 1'b0) begin
      $display("FAIL busy_x4_last_rel: got %b expected 0", bus.rs_busy[0]); err_cnt++;
    end
    // cnt=0: one more release must flag underflow from the next cycle on
    @(negedge clk);
    idle();
    bus.wr_en      = 2'b01;
    bus.wr_release = 2'b01;
    bus.wr_addr    = {5'd0, 5'd4};
    #1;
    vec_cnt++;
    if (bus.sb_underflow !== 1'b0) begin
      $display("FAIL underflow_x4_pre: got %b expected 0", bus.sb_underflow); err_cnt++;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      #1;
      vec_cnt++;
      if (bus.sb_underflow !== 1'b1) begin
        $display("FAIL underflow_x4_sticky_%0d: got %b expected 1", k, bus.sb_underflow); err_cnt++;
      end
    end
  endtask

  task automatic test_flush_reset();
    repeat (2) begin
      @(negedge clk);
      idle();
      bus.rsv_en   = 1'b1;
      bus.rsv_addr = 5'd9;
    end
    @(negedge clk);
    idle();
    bus.rs_addr = {5'd9, 5'd9};
    #1;
    vec_cnt++;
    if (bus.rs_busy !== 2'b11) begin
      $display("FAIL busy_x9_rsv: got %b expected 11", bus.rs_busy); err_cnt++;
    end
    @(negedge clk);
    idle();
    bus.flush    = 1'b1;
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd9;
    bus.wr_en    = 2'b01;
    bus.wr_addr  = {5'd0, 5'd9};
    bus.wr_data  = {32'h0, 32'h99};
    @(negedge clk);
    idle();
    bus.rsv_addr = 5'd9;
    #1;
    vec_cnt++;
    if (bus.rs_busy !== 2'b00) begin
      $display("FAIL busy_x9_flush: got %b expected 00", bus.rs_busy); err_cnt++;
    end
    vec_cnt++;
    if (bus.rs_data !== {32'h99, 32'h99}) begin
      $display("FAIL data_x9_flush: got %h expected 0000009900000099", bus.rs_data); err_cnt++;
    end
    vec_cnt++;
    if (bus.rsv_ready !== 1'b1) begin
      $display("FAIL rsv_ready_x9_flush: got %b expected 1", bus.rsv_ready); err_cnt++;
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    vec_cnt++;
    if (bus.rsv_ready !== 1'b0) begin
      $display("FAIL async_rst_ready: got %b expected 0", bus.rsv_ready); err_cnt++;
    end
    vec_cnt++;
    if (bus.rs_data !== 64'h0) begin
      $display("FAIL async_rst_data: got %h expected 0", bus.rs_data); err_cnt++;
    end
    vec_cnt++;
    if (bus.sb_underflow !== 1'b0) begin
      $display("FAIL async_rst_underflow: got %b expected 0", bus.sb_underflow); err_cnt++;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vec_cnt++;
    if (bus.rs_data !== 64'h0) begin
      $display("FAIL x9_after_reset: got %h expected 0", bus.rs_data); err_cnt++;
    end
    vec_cnt++;
    if (bus.rsv_ready !== 1'b1) begin
      $display("FAIL rsv_ready_after_reset: got %b expected 1", bus.rsv_ready); err_cnt++;
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    bus.rs_addr = '0;
    test_reset();
    test_write_bypass();
    test_priority();
    test_reserve_x3();
    test_release_x4();
    test_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
